// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for an in-order pipeline.
// It keeps a shadow pipeline of destination descriptors, one slot per stage
// after ID (slot 1 = EX ... slot DEPTH = WB). From those slots and the ID
// instruction it produces stall, flush and per-source forward selects.
//
// Optional feature: macro HAZARD_HOLD_EN adds i_hold, a global freeze.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_id_*              ID instruction descriptor (valid, sources, dest, load)
//   i_br_taken          redirect resolved in slot BR_STAGE
//   i_hold              global freeze (HAZARD_HOLD_EN only)
//   o_stall             hold PC and IF/ID, bubble into EX (combinational)
//   o_flush_if/_id      kill IF/ID content and ID/EX input (combinational)
//   o_fwd_sel_rs1/rs2   0 = register file, k = forward from slot k (combinational)
//   o_stall_cnt         saturating count of stall cycles (registered)
//   o_flush_cnt         saturating count of taken redirects (registered)
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned ALU_RDY  = 1,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned BR_STAGE = 1,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_vld,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_rd_wren,
  input  logic              i_id_is_load,
  input  logic              i_br_taken,
`ifdef HAZARD_HOLD_EN
  input  logic              i_hold,
`endif
  output logic              o_stall,
  output logic              o_flush_if,
  output logic              o_flush_id,
  output logic [SEL_W-1:0]  o_fwd_sel_rs1,
  output logic [SEL_W-1:0]  o_fwd_sel_rs2,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
);

  localparam int ALU_T  = int'(ALU_RDY);
  localparam int LOAD_T = int'(LOAD_RDY);
  localparam int BR_T   = int'(BR_STAGE);
  localparam int DEP_T  = int'(DEPTH);

  // Shadow pipeline slots, index 1 is the youngest (EX).
  logic [DEPTH:1]    slot_vld;
  logic [DEPTH:1]    slot_wren;
  logic [DEPTH:1]    slot_ld;
  logic [REG_AW-1:0] slot_rd [1:DEPTH];

  logic hold;
  logic br;
  logic nr1;
  logic nr2;

  // Youngest-match search per source, readiness, stall and flush.
  always_comb begin
    hold          = 1'b0;
`ifdef HAZARD_HOLD_EN
    hold          = i_hold;
`endif
    br            = i_br_taken & ~hold;
    o_fwd_sel_rs1 = '0;
    o_fwd_sel_rs2 = '0;
    nr1           = 1'b0;
    nr2           = 1'b0;
    // Descending scan so the lowest matching index overwrites older ones.
    for (int k = DEP_T; k >= 1; k--) begin
      if (slot_vld[k] && slot_wren[k] && slot_rd[k] == i_id_rs1_addr &&
          i_id_rs1_addr != '0 && i_id_use_rs1 && i_id_vld) begin
        o_fwd_sel_rs1 = SEL_W'(k);
        nr1           = (k < (slot_ld[k] ? LOAD_T : ALU_T));
      end
      if (slot_vld[k] && slot_wren[k] && slot_rd[k] == i_id_rs2_addr &&
          i_id_rs2_addr != '0 && i_id_use_rs2 && i_id_vld) begin
        o_fwd_sel_rs2 = SEL_W'(k);
        nr2           = (k < (slot_ld[k] ? LOAD_T : ALU_T));
      end
    end
    o_stall    = hold | ((nr1 | nr2) & ~br);
    o_flush_if = br;
    o_flush_id = br;
  end

  // Slot advance and saturating counters; everything freezes under hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_vld    <= '0;
      slot_wren   <= '0;
      slot_ld     <= '0;
      for (int k = 1; k <= DEP_T; k++) slot_rd[k] <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (!hold) begin
      for (int k = DEP_T; k >= 2; k--) begin
        // A redirect kills the younger work that sits ahead of the branch.
        slot_vld[k]  <= slot_vld[k-1] & ~(br && (k <= BR_T));
        slot_wren[k] <= slot_wren[k-1];
        slot_ld[k]   <= slot_ld[k-1];
        slot_rd[k]   <= slot_rd[k-1];
      end
      slot_vld[1]  <= i_id_vld & ~o_stall & ~br;
      slot_wren[1] <= i_id_rd_wren;
      slot_ld[1]   <= i_id_is_load;
      slot_rd[1]   <= i_id_rd_addr;
      if (o_stall && o_stall_cnt != 32'hFFFF_FFFF) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (br && o_flush_cnt != 32'hFFFF_FFFF)      o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with default parameters
// (DEPTH=3, ALU_RDY=1, LOAD_RDY=2, BR_STAGE=1).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_vld = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        use1 = 1'b0, use2 = 1'b0, wren = 1'b0, ld = 1'b0;
  logic        br = 1'b0;
  logic        hold = 1'b0;
  logic        stall, flush_if, flush_id;
  logic [1:0]  sel1, sel2;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .i_clk(clk), .i_rst(rst), .i_id_vld(id_vld),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_rd_addr(rd), .i_id_rd_wren(wren), .i_id_is_load(ld),
    .i_br_taken(br),
`ifdef HAZARD_HOLD_EN
    .i_hold(hold),
`endif
    .o_stall(stall), .o_flush_if(flush_if), .o_flush_id(flush_id),
    .o_fwd_sel_rs1(sel1), .o_fwd_sel_rs2(sel2),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  // Present an ID instruction; outputs settle 1 time unit later.
  task automatic set_id(input logic v, input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic [4:0] d, input logic w, input logic l);
    id_vld = v; rs1 = a1; use1 = u1; rs2 = a2; use2 = u2; rd = d; wren = w; ld = l;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (sel1 !== 2'd0 || sel2 !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d/%0d want 0/0", sel1, sel2); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0h/%0h want 0/0", stall_cnt, flush_cnt); end
    checks++; if (flush_if !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b%0b want 00", flush_if, flush_id); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_fwd();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // add x5
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // x8 = f(x5)
    checks++; if (stall !== 1'b0 || sel1 !== 2'd1) begin errors++; $display("FAIL alu_s1 got stall=%0b sel1=%0d want 0/1", stall, sel1); end
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++; if (sel1 !== 2'd2 || sel2 !== 2'd1 || stall !== 1'b0) begin errors++; $display("FAIL alu_s2 got sel=%0d/%0d stall=%0b want 2/1/0", sel1, sel2, stall); end
    step();
    checks++; if (sel1 !== 2'd3 || sel2 !== 2'd2) begin errors++; $display("FAIL alu_s3 got sel=%0d/%0d want 3/2", sel1, sel2); end
    step();
    checks++; if (sel1 !== 2'd0 || sel2 !== 2'd3) begin errors++; $display("FAIL alu_retire got sel=%0d/%0d want 0/3", sel1, sel2); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1 || sel2 !== 2'd1) begin errors++; $display("FAIL lu_stall got stall=%0b sel2=%0d want 1/1", stall, sel2); end
    step();
    checks++; if (stall !== 1'b0 || sel2 !== 2'd2) begin errors++; $display("FAIL lu_release got stall=%0b sel2=%0d want 0/2", stall, sel2); end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    step();
    idle();
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt); end
    drain();
  endtask

  task automatic test_multi_producer();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);   // x7 (ends in slot 3)
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // writes x0
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);   // x7 (slot 1)
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++; if (sel1 !== 2'd1) begin errors++; $display("FAIL multi_young got sel1=%0d want 1", sel1); end
    checks++; if (sel2 !== 2'd0 || stall !== 1'b0) begin errors++; $display("FAIL multi_x0 got sel2=%0d stall=%0b want 0/0", sel2, stall); end
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b0 || sel1 !== 2'd0) begin errors++; $display("FAIL x0_load got stall=%0b sel1=%0d want 0/0", stall, sel1); end
    drain();
  endtask

  task automatic test_branch();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0);
    br = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_stall got %0b want 0", stall); end
    checks++; if (flush_if !== 1'b1 || flush_id !== 1'b1) begin errors++; $display("FAIL br_flush got %0b%0b want 11", flush_if, flush_id); end
    step();
    br = 1'b0;
    set_id(1'b1, 5'd10, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL br_killed got sel1=%0d want 0", sel1); end
    checks++; if (sel2 !== 2'd2 || stall !== 1'b0) begin errors++; $display("FAIL br_older got sel2=%0d stall=%0b want 2/0", sel2, stall); end
    checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin errors++; $display("FAIL br_cnt got flush=%0d stall=%0d want 1/1", flush_cnt, stall_cnt); end
    drain();
  endtask

`ifdef HAZARD_HOLD_EN
  task automatic test_hold();
    logic [31:0] sc, fc;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // add x5
    step();
    sc = stall_cnt; fc = flush_cnt;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      br = (i == 1); #1;
      checks++; if (stall !== 1'b1 || sel1 !== 2'd1) begin errors++; $display("FAIL hold_%0d got stall=%0b sel1=%0d want 1/1", i, stall, sel1); end
      step();
    end
    br = 1'b0; hold = 1'b0; #1;
    checks++; if (stall_cnt !== sc || flush_cnt !== fc) begin errors++; $display("FAIL hold_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, sc, fc); end
    checks++; if (stall !== 1'b0 || sel1 !== 2'd1) begin errors++; $display("FAIL hold_resume got stall=%0b sel1=%0d want 0/1", stall, sel1); end
    drain();
  endtask
`endif

  task automatic test_saturation();
    idle();
    force dut.o_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.o_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall_%0d got %0b want 1", i, stall); end
      step();
      idle();
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_cnt_%0d got %0h want ffffffff", i, stall_cnt); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0b want 1", stall); end
    rst = 1'b1; #1;
    checks++; if (stall !== 1'b0 || sel1 !== 2'd0) begin errors++; $display("FAIL rmid_slots got stall=%0b sel1=%0d want 0/0", stall, sel1); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rmid_cnt got %0h/%0h want 0/0", stall_cnt, flush_cnt); end
    @(negedge clk);
    rst = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_multi_producer();
    test_branch();
`ifdef HAZARD_HOLD_EN
    test_hold();
`endif
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Keeps an internal shadow pipeline of in-flight destination descriptors, one slot per stage after ID.
- From that state it produces stall, flush and per-source forward-select for the instruction in ID.
- Sits beside the stage buffers; replaces the fixed-depth hazard logic so depth, load latency and branch-resolve stage are configurable.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (slot 1 = EX … slot DEPTH = WB); legal range 2..7.
- ALU_RDY, 1, first slot whose non-load result is forwardable.
- LOAD_RDY, 2, first slot whose load result is forwardable; must be ≥ ALU_RDY and ≤ DEPTH.
- BR_STAGE, 1, slot in which a branch/jump resolves; legal range 1..DEPTH-1.
- SEL_W, $clog2(DEPTH+1), forward-select width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_id_vld  in  1  ID holds a valid instruction.
- i_id_rs1_addr  in  REG_AW  ID source 1.
- i_id_rs2_addr  in  REG_AW  ID source 2.
- i_id_use_rs1  in  1  ID reads rs1.
- i_id_use_rs2  in  1  ID reads rs2.
- i_id_rd_addr  in  REG_AW  ID destination.
- i_id_rd_wren  in  1  ID writes rd.
- i_id_is_load  in  1  ID is a load.
- i_br_taken  in  1  redirect from slot BR_STAGE.
- i_hold  in  1  global freeze; present only with HAZARD_HOLD_EN.
- o_stall  out  1  hold PC and IF/ID; bubble into EX.
- o_flush_if  out  1  kill IF/ID buffer content.
- o_flush_id  out  1  kill ID/EX buffer input.
- o_fwd_sel_rs1  out  SEL_W  0 = register file, k = slot k.
- o_fwd_sel_rs2  out  SEL_W  same encoding for rs2.
- o_stall_cnt  out  32  cycles with o_stall asserted.
- o_flush_cnt  out  32  taken redirects.

Behaviour:
- Slot state: vld, rd, wren, is_load for each of slots 1..DEPTH.
- Reset: all slot vld = 0; both counters = 0. Hence o_stall = 0 and fwd_sel = 0. o_flush_* are 0 provided i_br_taken = 0.
- Reset mid-operation: clears immediately (asynchronous). Release is synchronised by the caller.
- Matching: slot k matches source s when vld & wren & rd == s & s != 0 & use_s & i_id_vld.
- Forward select: the lowest-index (youngest) matching slot k, else 0. Older matches are ignored.
- Readiness: matching slot k is ready if k ≥ (is_load ? LOAD_RDY : ALU_RDY).
- Stall: o_stall = (youngest match for rs1 or rs2 not ready) & ~i_br_taken.
- While o_stall = 1, fwd_sel still reports the youngest match, even though it is not yet ready.
- Flush: o_flush_if = o_flush_id = i_br_taken.
- Priority: a branch outranks a stall in the same cycle; the ID instruction is killed and no stall is counted.
- All stall/flush/fwd outputs are combinational (zero latency) from slot state and ID inputs.
- Clock edge, no hold:
  - slot[k] <= slot[k-1] for k = 2..DEPTH; slot DEPTH retires.
  - slot[1] <= ID descriptor, with vld = i_id_vld & ~o_stall & ~i_br_taken.
  - When i_br_taken, the next slot[2..BR_STAGE] are forced invalid (younger in-flight work). No effect when BR_STAGE = 1.
- Counters:
  - o_stall_cnt += 1 on each cycle with o_stall.
  - o_flush_cnt += 1 on each cycle with i_br_taken.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- rd = x0 is never tracked as a hazard, regardless of wren.

Optional Feature:
- Macro: HAZARD_HOLD_EN.
- Defined: i_hold port exists. While i_hold = 1:
  - all slots and counters keep their value;
  - o_stall is forced to 1, but o_stall_cnt does not count;
  - an i_br_taken during hold is ignored, and the caller must keep it asserted until hold drops;
  - fwd_sel outputs stay as computed.
- Undefined: no i_hold port; behaviour equals i_hold = 0.

Test Plan:
- ALU back-to-back: `add x5` (slot 1, not load), then ID reads rs1 = x5 -> o_stall = 0, o_fwd_sel_rs1 = 1.
- Load-use: `lw x6` in slot 1, ID uses rs2 = x6 -> o_stall = 1 for exactly 1 cycle, then o_fwd_sel_rs2 = 2, o_stall_cnt = 1.
- Multiple producers: x7 written in slots 1 and 3, ID reads x7 -> fwd_sel = 1. Any source = x0 with a matching writer -> fwd_sel = 0, no stall.
- Branch during load-use: i_br_taken = 1 with a pending load-use -> o_stall = 0, o_flush_if = o_flush_id = 1, next slot 1 invalid, o_flush_cnt += 1.
- Saturation: preload o_stall_cnt via a 2^32 stall run, or a force to 32'hFFFF_FFFE, then 3 stall cycles -> count holds at 32'hFFFF_FFFF.
- HAZARD_HOLD_EN: assert i_hold for 4 cycles mid-sequence -> slot contents and counters unchanged, o_stall = 1, and forwarding resumes identically after release.
